// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// Size encodings follow the eBPF BPF_SIZE field.
package mem_arbiter_pkg;

    localparam logic [1:0] SZ_W  = 2'b00;
    localparam logic [1:0] SZ_H  = 2'b01;
    localparam logic [1:0] SZ_B  = 2'b10;
    localparam logic [1:0] SZ_DW = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Ones covering the access width, right-aligned.
    function automatic logic [63:0] size_mask(input logic [1:0] size);
        logic [63:0] m;
        case (size)
            SZ_B:    m = 64'h0000_0000_0000_00FF;
            SZ_H:    m = 64'h0000_0000_0000_FFFF;
            SZ_W:    m = 64'h0000_0000_FFFF_FFFF;
            default: m = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return m;
    endfunction

    // Natural alignment: offset must be a multiple of the access width.
    function automatic logic is_aligned(input logic [1:0] size,
                                        input logic [2:0] offset);
        logic ok;
        case (size)
            SZ_DW:   ok = (offset == 3'd0);
            SZ_W:    ok = (offset[1:0] == 2'd0);
            SZ_H:    ok = !offset[0];
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian byte-lane extract for loads and
// read-merge-write word construction for stores.
module mem_lane_align
    import mem_arbiter_pkg::*;
(
    input  logic [63:0] i_word,
    input  logic [63:0] i_wdata,
    input  logic [1:0]  i_size,
    input  logic [2:0]  i_offset,
    output logic [63:0] o_load_val,
    output logic [63:0] o_merged_word
);

    logic [5:0]  w_shift;
    logic [63:0] w_mask;
    logic [63:0] w_lane_mask;

    // Shift lanes by offset bytes; DW replaces the whole word.
    always_comb begin
        w_shift     = {i_offset, 3'b000};
        w_mask      = size_mask(i_size);
        w_lane_mask = w_mask << w_shift;
        o_load_val  = (i_word >> w_shift) & w_mask;
        if (i_size == SZ_DW) begin
            o_merged_word = i_wdata;
        end else begin
            o_merged_word = (i_word & ~w_lane_mask)
                          | ((i_wdata & w_mask) << w_shift);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the 64-bit data memory between
// the eBPF load/store unit (r0) and the host loader port (r1).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int DATA_SIZE    = 64,
    parameter int ADDRESS_SIZE = 12
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      r0_req,
    input  logic                      r0_we,
    input  logic [1:0]                r0_size,
    input  logic [ADDRESS_SIZE+2:0]   r0_addr,
    input  logic [DATA_SIZE-1:0]      r0_wdata,
    output logic                      r0_ack,
    output logic [DATA_SIZE-1:0]      r0_rdata,
    output logic                      r0_err,

    input  logic                      r1_req,
    input  logic                      r1_we,
    input  logic [1:0]                r1_size,
    input  logic [ADDRESS_SIZE+2:0]   r1_addr,
    input  logic [DATA_SIZE-1:0]      r1_wdata,
    output logic                      r1_ack,
    output logic [DATA_SIZE-1:0]      r1_rdata,
    output logic                      r1_err,

    output logic [ADDRESS_SIZE-1:0]   mem_address,
    output logic [DATA_SIZE-1:0]      mem_data_in,
    input  logic [DATA_SIZE-1:0]      mem_data_out,
    output logic                      mem_write_enable
);

    state_t                    r_state;
    logic                      r_rr_last;
    logic                      r_gid;
    logic                      r_we;
    logic [1:0]                r_size;
    logic [ADDRESS_SIZE+2:0]   r_addr;
    logic [DATA_SIZE-1:0]      r_wdata;
    logic [DATA_SIZE-1:0]      r_rdata;
    logic                      r_err;
    logic                      r_ack0;
    logic                      r_ack1;

    logic [2:0]                w_offset;
    logic                      w_aligned;
    logic                      w_gnt1;
    logic [DATA_SIZE-1:0]      w_load_val;
    logic [DATA_SIZE-1:0]      w_merged;

    assign w_offset  = r_addr[2:0];
    assign w_aligned = is_aligned(r_size, w_offset);

    // r1 wins alone, or on a tie when r0 was served last.
    assign w_gnt1 = r1_req && (!r0_req || !r_rr_last);

    mem_lane_align u_align (
        .i_word        (mem_data_out),
        .i_wdata       (r_wdata),
        .i_size        (r_size),
        .i_offset      (w_offset),
        .o_load_val    (w_load_val),
        .o_merged_word (w_merged)
    );

    assign mem_address      = r_addr[ADDRESS_SIZE+2:3];
    assign mem_data_in      = w_merged;
    assign mem_write_enable = (r_state == ACCESS) && r_we
                            && w_aligned && !rst;

    assign r0_ack   = r_ack0;
    assign r1_ack   = r_ack1;
    assign r0_rdata = r_ack0 ? r_rdata : '0;
    assign r1_rdata = r_ack1 ? r_rdata : '0;
    assign r0_err   = r_ack0 & r_err;
    assign r1_err   = r_ack1 & r_err;

    // Grant, access and respond; one transaction per three cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_rr_last <= 1'b1;
            r_gid     <= 1'b0;
            r_we      <= 1'b0;
            r_size    <= 2'b00;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (r0_req || r1_req) begin
                        r_gid   <= w_gnt1;
                        r_we    <= w_gnt1 ? r1_we    : r0_we;
                        r_size  <= w_gnt1 ? r1_size  : r0_size;
                        r_addr  <= w_gnt1 ? r1_addr  : r0_addr;
                        r_wdata <= w_gnt1 ? r1_wdata : r0_wdata;
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    r_err     <= !w_aligned;
                    r_rdata   <= (w_aligned && !r_we) ? w_load_val : '0;
                    r_ack0    <= !r_gid;
                    r_ack1    <= r_gid;
                    r_rr_last <= r_gid;
                    r_state   <= RESP;
                end
                RESP: begin
                    r_rdata <= '0;
                    r_err   <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural
// 64-bit memory model on the shared port.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        r0_req, r0_we, r0_ack, r0_err;
    logic [1:0]  r0_size;
    logic [14:0] r0_addr;
    logic [63:0] r0_wdata, r0_rdata;
    logic        r1_req, r1_we, r1_ack, r1_err;
    logic [1:0]  r1_size;
    logic [14:0] r1_addr;
    logic [63:0] r1_wdata, r1_rdata;
    logic [11:0] mem_address;
    logic [63:0] mem_data_in, mem_data_out;
    logic        mem_write_enable;

    logic [63:0] mem [0:4095];

    int n_vec;
    int n_bad;

    logic [63:0] o_rd;
    logic        o_er, o_oth, o_to;
    int          o_lat, o_wec;

    localparam logic [63:0] P1 = 64'h0101_0202_0303_0404;
    localparam logic [63:0] P2 = 64'hA5A5_5A5A_DEAD_BEEF;
    localparam logic [63:0] P5 = 64'h1122_3344_5566_7788;
    localparam logic [63:0] P6 = 64'h0F1E_2D3C_4B5A_6978;

    mem_arbiter #(.DATA_SIZE(64), .ADDRESS_SIZE(12)) dut (
        .clk              (clk),
        .rst              (rst),
        .r0_req           (r0_req),
        .r0_we            (r0_we),
        .r0_size          (r0_size),
        .r0_addr          (r0_addr),
        .r0_wdata         (r0_wdata),
        .r0_ack           (r0_ack),
        .r0_rdata         (r0_rdata),
        .r0_err           (r0_err),
        .r1_req           (r1_req),
        .r1_we            (r1_we),
        .r1_size          (r1_size),
        .r1_addr          (r1_addr),
        .r1_wdata         (r1_wdata),
        .r1_ack           (r1_ack),
        .r1_rdata         (r1_rdata),
        .r1_err           (r1_err),
        .mem_address      (mem_address),
        .mem_data_in      (mem_data_in),
        .mem_data_out     (mem_data_out),
        .mem_write_enable (mem_write_enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_data_out = mem[mem_address];

    always @(posedge clk) begin
        if (mem_write_enable) mem[mem_address] <= mem_data_in;
    end

    // Drive one request and wait (bounded) for its ack.
    task automatic issue(input int id, input logic we,
                         input logic [1:0] sz, input logic [14:0] a,
                         input logic [63:0] wd);
        o_rd = '0; o_er = 1'b0; o_lat = 0;
        o_wec = 0; o_oth = 1'b0; o_to = 1'b1;
        if (id == 0) begin
            r0_we = we; r0_size = sz; r0_addr = a;
            r0_wdata = wd; r0_req = 1'b1;
        end else begin
            r1_we = we; r1_size = sz; r1_addr = a;
            r1_wdata = wd; r1_req = 1'b1;
        end
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (mem_write_enable) o_wec++;
            if (id == 0 ? r1_ack : r0_ack) o_oth = 1'b1;
            if (id == 0 ? r0_ack : r1_ack) begin
                o_rd  = (id == 0) ? r0_rdata : r1_rdata;
                o_er  = (id == 0) ? r0_err : r1_err;
                o_lat = c;
                o_to  = 1'b0;
                break;
            end
        end
        r0_req = 1'b0;
        r1_req = 1'b0;
        @(posedge clk); #1;
        if (mem_write_enable) o_wec++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({r0_ack, r1_ack} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_ack got=%b want=00", {r0_ack, r1_ack});
        end
        n_vec++;
        if ({r0_err, r1_err, mem_write_enable} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_err_we got=%b want=000",
                     {r0_err, r1_err, mem_write_enable});
        end
        n_vec++;
        if ((r0_rdata | r1_rdata) !== 64'h0) begin
            n_bad++;
            $display("FAIL reset_rdata got=%h/%h want=0",
                     r0_rdata, r1_rdata);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin();
        int ids [4];
        int cyc [4];
        logic [63:0] dat [4];
        int na;
        na = 0;
        rst = 1'b1;
        r0_we = 1'b0; r0_size = 2'b11; r0_addr = 15'h0008;
        r1_we = 1'b0; r1_size = 2'b11; r1_addr = 15'h0010;
        r0_req = 1'b1; r1_req = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 1; c <= 20 && na < 4; c++) begin
            @(posedge clk); #1;
            if (r0_ack && r1_ack) begin
                n_vec++; n_bad++;
                $display("FAIL rr_dual_ack cycle=%0d", c);
            end else if (r0_ack || r1_ack) begin
                ids[na] = r1_ack ? 1 : 0;
                cyc[na] = c;
                dat[na] = r1_ack ? r1_rdata : r0_rdata;
                na++;
            end
        end
        r0_req = 1'b0; r1_req = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (na !== 4) begin
            n_bad++;
            $display("FAIL rr_count got=%0d want=4", na);
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_vec++;
                if (ids[k] !== (k % 2)) begin
                    n_bad++;
                    $display("FAIL rr_order[%0d] got=r%0d want=r%0d",
                             k, ids[k], k % 2);
                end
                n_vec++;
                if (cyc[k] !== 2 + 3 * k) begin
                    n_bad++;
                    $display("FAIL rr_cycle[%0d] got=%0d want=%0d",
                             k, cyc[k], 2 + 3 * k);
                end
                n_vec++;
                if (dat[k] !== ((k % 2 == 0) ? P1 : P2)) begin
                    n_bad++;
                    $display("FAIL rr_data[%0d] got=%h want=%h",
                             k, dat[k], (k % 2 == 0) ? P1 : P2);
                end
            end
        end
    endtask

    task automatic test_load_byte();
        issue(0, 1'b0, 2'b10, 15'h002B, 64'h0);
        n_vec++;
        if (o_to || o_lat !== 2) begin
            n_bad++;
            $display("FAIL ldb_latency got=%0d to=%b want=2", o_lat, o_to);
        end
        n_vec++;
        if (o_rd !== 64'h55 || o_er !== 1'b0) begin
            n_bad++;
            $display("FAIL ldb_data got=%h err=%b want=55 err=0",
                     o_rd, o_er);
        end
    endtask

    task automatic test_store_byte();
        issue(0, 1'b1, 2'b10, 15'h002B, 64'hFFFF_FFFF_FFFF_FFAB);
        n_vec++;
        if (o_to || o_er !== 1'b0) begin
            n_bad++;
            $display("FAIL stb_ack to=%b err=%b want ack err=0", o_to, o_er);
        end
        n_vec++;
        if (mem[5] !== 64'h1122_3344_AB66_7788) begin
            n_bad++;
            $display("FAIL stb_word got=%h want=11223344ab667788", mem[5]);
        end
        n_vec++;
        if (o_wec !== 1) begin
            n_bad++;
            $display("FAIL stb_we_cycles got=%0d want=1", o_wec);
        end
        n_vec++;
        if (o_oth !== 1'b0) begin
            n_bad++;
            $display("FAIL stb_r1_ack got=%b want=0", o_oth);
        end
    endtask

    task automatic test_misaligned();
        issue(1, 1'b0, 2'b00, 15'h002A, 64'h0);
        n_vec++;
        if (o_to || o_er !== 1'b1 || o_rd !== 64'h0) begin
            n_bad++;
            $display("FAIL mis_ldw to=%b err=%b rd=%h want err=1 rd=0",
                     o_to, o_er, o_rd);
        end
        n_vec++;
        if (o_wec !== 0 || o_oth !== 1'b0) begin
            n_bad++;
            $display("FAIL mis_ldw_side we=%0d r0ack=%b want 0/0",
                     o_wec, o_oth);
        end
        issue(0, 1'b1, 2'b01, 15'h002D, 64'h0000_0000_0000_BEEF);
        n_vec++;
        if (o_to || o_er !== 1'b1 || o_wec !== 0) begin
            n_bad++;
            $display("FAIL mis_sth to=%b err=%b we=%0d want err=1 we=0",
                     o_to, o_er, o_wec);
        end
        n_vec++;
        if (mem[5] !== 64'h1122_3344_AB66_7788) begin
            n_bad++;
            $display("FAIL mis_word got=%h want=11223344ab667788", mem[5]);
        end
    endtask

    task automatic test_half_and_dword();
        issue(0, 1'b0, 2'b01, 15'h002C, 64'h0);
        n_vec++;
        if (o_to || o_rd !== 64'h3344 || o_er !== 1'b0) begin
            n_bad++;
            $display("FAIL ldh got=%h err=%b want=3344 err=0", o_rd, o_er);
        end
        issue(0, 1'b1, 2'b11, 15'h0028, 64'hFFFF_0000_FFFF_0000);
        n_vec++;
        if (o_to || mem[5] !== 64'hFFFF_0000_FFFF_0000) begin
            n_bad++;
            $display("FAIL stdw got=%h want=ffff0000ffff0000", mem[5]);
        end
        issue(1, 1'b1, 2'b00, 15'h002C, 64'hDEAD_BEEF_1234_5678);
        n_vec++;
        if (o_to || mem[5] !== 64'h1234_5678_FFFF_0000) begin
            n_bad++;
            $display("FAIL r1_stw got=%h want=12345678ffff0000", mem[5]);
        end
        issue(1, 1'b0, 2'b10, 15'h002F, 64'h0);
        n_vec++;
        if (o_to || o_rd !== 64'h12) begin
            n_bad++;
            $display("FAIL r1_ldb got=%h want=12", o_rd);
        end
    endtask

    task automatic test_reset_mid_op();
        int acks;
        acks = 0;
        r0_we = 1'b1; r0_size = 2'b10; r0_addr = 15'h0030;
        r0_wdata = 64'hCD; r0_req = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (mem_write_enable !== 1'b1) begin
            n_bad++;
            $display("FAIL rmid_access_we got=%b want=1", mem_write_enable);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if (mem_write_enable !== 1'b0) begin
            n_bad++;
            $display("FAIL rmid_gated_we got=%b want=0", mem_write_enable);
        end
        @(posedge clk); #1;
        r0_req = 1'b0;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (r0_ack || r1_ack) acks++;
            @(posedge clk); #1;
        end
        n_vec++;
        if (acks !== 0) begin
            n_bad++;
            $display("FAIL rmid_ack got=%0d acks want=0", acks);
        end
        n_vec++;
        if (mem[6] !== P6) begin
            n_bad++;
            $display("FAIL rmid_word got=%h want=%h", mem[6], P6);
        end
        issue(0, 1'b0, 2'b11, 15'h0030, 64'h0);
        n_vec++;
        if (o_to || o_lat !== 2 || o_rd !== P6) begin
            n_bad++;
            $display("FAIL rmid_retry lat=%0d rd=%h want lat=2 rd=%h",
                     o_lat, o_rd, P6);
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst = 1'b1;
        r0_req = 1'b0; r0_we = 1'b0; r0_size = 2'b00;
        r0_addr = '0; r0_wdata = '0;
        r1_req = 1'b0; r1_we = 1'b0; r1_size = 2'b00;
        r1_addr = '0; r1_wdata = '0;
        for (int i = 0; i < 4096; i++) mem[i] = 64'h0;
        mem[1] = P1;
        mem[2] = P2;
        mem[5] = P5;
        mem[6] = P6;

        test_reset();
        test_round_robin();
        test_load_byte();
        test_store_byte();
        test_misaligned();
        test_half_and_dword();
        test_reset_mid_op();

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
